// File: rtl/mem_port_arbiter.sv
// Shares the single Memory port between instruction fetch and load/store.
// Latency: grant and memory drive in the request cycle, rvalid/rdata one cycle later.
// Backpressure: a requester holds its request until granted; one access per two cycles.
module mem_port_arbiter #(
  parameter int         MAX_DATA_STREAK = 4,
  parameter logic [2:0] FETCH_RD_TYPE   = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_wtype,
  input  logic [2:0]  d_rtype,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_write_type,
  output logic [2:0]  mem_rd_type,
  input  logic [31:0] mem_out
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] streak;
  // High for the cycle right after a reset edge so nothing is granted while reset is still settling.
  logic       rst_seen;
  logic       if_rvalid_q;
  logic       d_rvalid_q;
  logic       arb_ok;
  logic       gnt_i;
  logic       gnt_d;

  // Arbitration: data first, unless fetch has waited through a full streak of data grants.
  always_comb begin
    arb_ok = (state == IDLE) && !rst_seen;
    gnt_d  = arb_ok && d_req && !(if_req && (streak == MAX_STREAK));
    gnt_i  = arb_ok && if_req && !gnt_d;
  end

  assign if_gnt = gnt_i;
  assign d_gnt  = gnt_d;

  // A reset arriving during the response cycle swallows the pending rvalid.
  assign if_rvalid = if_rvalid_q & rst;
  assign d_rvalid  = d_rvalid_q & rst;

  // Memory port is driven only during a grant cycle; otherwise everything reads as zero.
  always_comb begin
    mem_addr       = '0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_wr_data    = '0;
    mem_write_type = '0;
    mem_rd_type    = '0;
    if (gnt_i) begin
      mem_addr    = if_addr;
      mem_read_en = 1'b1;
      mem_rd_type = FETCH_RD_TYPE;
    end else if (gnt_d) begin
      mem_addr       = d_addr;
      // Read stays on even for stores: partial stores merge with the old word.
      mem_read_en    = 1'b1;
      mem_write_en   = d_we;
      mem_wr_data    = d_wdata;
      mem_write_type = d_wtype;
      mem_rd_type    = d_rtype;
    end
  end

  // State machine, streak tracking and registered response capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      streak      <= '0;
      rst_seen    <= 1'b1;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      rst_seen    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_i) begin
            if_rdata    <= mem_out;
            if_rvalid_q <= 1'b1;
            streak      <= '0;
            state       <= RESP;
          end else if (gnt_d) begin
            d_rdata    <= d_we ? 32'd0 : mem_out;
            d_rvalid_q <= 1'b1;
            if (if_req) begin
              if (streak != MAX_STREAK) begin
                streak <= streak + 4'd1;
              end
            end else begin
              streak <= '0;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a cycle model.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Requesters hold their request until granted, as the handshake requires.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_wtype;
  logic [2:0]  d_rtype;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_write_type;
  logic [2:0]  mem_rd_type;
  logic [31:0] mem_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .FETCH_RD_TYPE(3'b010)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wtype(d_wtype), .d_rtype(d_rtype), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_wr_data(mem_wr_data), .mem_write_type(mem_write_type),
    .mem_rd_type(mem_rd_type), .mem_out(mem_out)
  );

  function automatic logic [138:0] pack_obs(
    input logic ig, input logic dg, input logic irv, input logic drv,
    input logic [31:0] ird, input logic [31:0] drd, input logic [31:0] addr,
    input logic re, input logic we, input logic [31:0] wd,
    input logic [1:0] wt, input logic [2:0] rt);
    return {ig, dg, irv, drv, ird, drd, addr, re, we, wd, wt, rt};
  endfunction

  function automatic logic [138:0] dut_obs();
    return pack_obs(if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata, mem_addr,
                    mem_read_en, mem_write_en, mem_wr_data, mem_write_type, mem_rd_type);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h44; d_addr = 32'h88; d_wdata = 32'h1; d_wtype = 2'b01; d_rtype = 3'b001;
    mem_out = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #3;
      checks++;
      if (dut_obs() !== 139'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, dut_obs());
      end
    end
    next_cycle();
    rst = 1'b1;
    #3;
    checks++;
    if ({if_gnt, d_gnt, mem_write_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_grants: got %b want 000", {if_gnt, d_gnt, mem_write_en});
    end
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_lone_fetch();
    if_req = 1'b1; if_addr = 32'h100; mem_out = 32'hDEAD_BEEF;
    #3;
    checks++;
    if ({if_gnt, d_gnt, mem_addr, mem_read_en, mem_write_en, mem_rd_type} !==
        {1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 3'b010}) begin
      errors++;
      $display("FAIL fetch_grant: got gnt=%b%b addr=%h re=%b we=%b rt=%b want 10 100 1 0 010",
               if_gnt, d_gnt, mem_addr, mem_read_en, mem_write_en, mem_rd_type);
    end
    next_cycle();
    if_req = 1'b0; mem_out = 32'h0BAD_0BAD;
    #3;
    checks++;
    if ({if_rvalid, if_rdata, if_gnt, mem_read_en} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_resp: got rv=%b rdata=%h gnt=%b re=%b want 1 deadbeef 0 0",
               if_rvalid, if_rdata, if_gnt, mem_read_en);
    end
    next_cycle();
    #3;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL fetch_hold: got rv=%b rdata=%h want 0 deadbeef", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55; d_wtype = 2'b00;
    d_rtype = 3'b100; mem_out = 32'h1234_5678;
    #3;
    checks++;
    if ({d_gnt, if_gnt, mem_addr, mem_read_en, mem_write_en, mem_wr_data, mem_write_type, mem_rd_type} !==
        {1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, 32'h55, 2'b00, 3'b100}) begin
      errors++;
      $display("FAIL store_grant: got gnt=%b addr=%h re=%b we=%b wd=%h wt=%b rt=%b",
               d_gnt, mem_addr, mem_read_en, mem_write_en, mem_wr_data, mem_write_type, mem_rd_type);
    end
    next_cycle();
    d_req = 1'b0;
    #3;
    checks++;
    if ({d_rvalid, d_rdata, mem_write_en} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL store_ack: got rv=%b rdata=%h we=%b want 1 0 0", d_rvalid, d_rdata, mem_write_en);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    mem_out = 32'h0;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (c % 2 == 1) exp_g = 2'b00;
      else if ((c / 2) % (MAXS + 1) == MAXS) exp_g = 2'b10;
      else exp_g = 2'b01;
      checks++;
      if ({if_gnt, d_gnt} !== exp_g) begin
        errors++;
        $display("FAIL contention_cycle%0d: got if/d=%b want %b", c, {if_gnt, d_gnt}, exp_g);
      end
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_out = 32'hA1;
    #3;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL simul_first: got if/d=%b want 01", {if_gnt, d_gnt});
    end
    next_cycle();
    d_req = 1'b0;
    #3;
    checks++;
    if ({if_gnt, d_gnt, d_rvalid, d_rdata} !== {2'b00, 1'b1, 32'hA1}) begin
      errors++;
      $display("FAIL simul_resp: got g=%b rv=%b rd=%h want 00 1 a1", {if_gnt, d_gnt}, d_rvalid, d_rdata);
    end
    next_cycle();
    mem_out = 32'hB2;
    #3;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL simul_fetch: got if/d=%b want 10", {if_gnt, d_gnt});
    end
    next_cycle();
    if_req = 1'b0;
    #3;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'hB2}) begin
      errors++;
      $display("FAIL simul_fetch_resp: got rv=%b rd=%h want 1 b2", if_rvalid, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_resp();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC0; mem_out = 32'hCAFE_F00D;
    #3;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant: got %b want 1", d_gnt);
    end
    next_cycle();
    d_req = 1'b0; rst = 1'b0;
    #3;
    checks++;
    if (d_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rvalid: got %b want 0", d_rvalid);
    end
    next_cycle();
    rst = 1'b1;
    #3;
    checks++;
    if ({d_rvalid, d_rdata} !== 33'd0) begin
      errors++;
      $display("FAIL midrst_rdata: got rv=%b rd=%h want 0 0", d_rvalid, d_rdata);
    end
    next_cycle();
    if_req = 1'b1; if_addr = 32'h40;
    #3;
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: got if_gnt=%b want 1", if_gnt);
    end
    next_cycle();
    if_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_grant_store();
    rst = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'h77;
    #3;
    checks++;
    if ({mem_write_en, mem_addr, mem_wr_data} !== {1'b1, 32'h3000, 32'h77}) begin
      errors++;
      $display("FAIL rstgnt_commit: got we=%b addr=%h wd=%h want 1 3000 77",
               mem_write_en, mem_addr, mem_wr_data);
    end
    next_cycle();
    d_req = 1'b0; rst = 1'b1;
    #3;
    checks++;
    if ({d_rvalid, if_rvalid, d_rdata} !== 34'd0) begin
      errors++;
      $display("FAIL rstgnt_drop: got drv=%b irv=%b rd=%h want 0 0 0", d_rvalid, if_rvalid, d_rdata);
    end
    next_cycle();
  endtask

  // Model: the memory port is busy the cycle after any grant; data wins unless fetch
  // has already watched MAXS data grants in a row go by.
  task automatic test_random();
    int         m_streak = 0;
    bit         m_resp = 1'b0;
    bit         m_own_d = 1'b0;
    logic [31:0] m_ird = '0;
    logic [31:0] m_drd = '0;
    bit         won_i = 1'b0;
    bit         won_d = 1'b0;
    bit         win_i, win_d;
    logic [138:0] exp_v;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!if_req || won_i) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
      if (!d_req || won_d) begin
        d_req = ($urandom_range(0, 3) != 0);
        d_we = $urandom_range(0, 1);
        d_addr = $urandom; d_wdata = $urandom;
        d_wtype = 2'($urandom_range(0, 3)); d_rtype = 3'($urandom_range(0, 7));
      end
      mem_out = $urandom;
      #3;
      won_i = 1'b0; won_d = 1'b0;
      if (m_resp) begin
        exp_v = pack_obs(1'b0, 1'b0, !m_own_d, m_own_d, m_ird, m_drd, 32'd0,
                         1'b0, 1'b0, 32'd0, 2'd0, 3'd0);
        m_resp = 1'b0;
      end else begin
        win_d = d_req && !(if_req && m_streak >= MAXS);
        win_i = if_req && !win_d;
        if (win_d)
          exp_v = pack_obs(1'b0, 1'b1, 1'b0, 1'b0, m_ird, m_drd, d_addr,
                           1'b1, d_we, d_wdata, d_wtype, d_rtype);
        else if (win_i)
          exp_v = pack_obs(1'b1, 1'b0, 1'b0, 1'b0, m_ird, m_drd, if_addr,
                           1'b1, 1'b0, 32'd0, 2'd0, 3'b010);
        else
          exp_v = pack_obs(1'b0, 1'b0, 1'b0, 1'b0, m_ird, m_drd, 32'd0,
                           1'b0, 1'b0, 32'd0, 2'd0, 3'd0);
        if (win_d) begin
          m_drd = d_we ? 32'd0 : mem_out;
          m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else if (win_i) begin
          m_ird = mem_out;
          m_streak = 0;
        end
        m_resp = win_i || win_d;
        m_own_d = win_d;
        won_i = win_i; won_d = win_d;
      end
      checks++;
      if (dut_obs() !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h want %h", c, dut_obs(), exp_v);
      end
      next_cycle();
    end
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wtype = '0; d_rtype = '0; mem_out = '0;
    #1;
    test_reset();
    test_lone_fetch();
    test_store();
    test_contention();
    test_simultaneous();
    test_reset_mid_resp();
    test_reset_grant_store();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single `Memory` port (RAM plus memory-mapped I/O) between the instruction-fetch unit and the load/store unit. Each side uses a request/grant/response handshake. The arbiter drives the `Memory` control inputs for the granted requester and returns the registered read data one cycle later. Data accesses have priority, bounded by a starvation limit that guarantees fetch progress.

## Interface
- `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while a fetch is pending before fetch must win; legal range 1..15.
- `FETCH_RD_TYPE`, default 3'b010: `rd_type` code driven for fetches (full 32-bit word).
- `clk`  in  1  system clock, all state changes on its rising edge
- `rst`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`
- `if_req`  in  1  fetch request; held until `if_gnt`
- `if_addr`  in  32  fetch byte address
- `if_gnt`  out  1  one-cycle grant pulse to fetch
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  32  fetched word
- `d_req`  in  1  data request; held with stable fields until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_wtype`  in  2  store width code, passed to `write_type`
- `d_rtype`  in  3  load type code, passed to `rd_type`
- `d_gnt`  out  1  one-cycle grant pulse to data
- `d_rvalid`  out  1  one-cycle pulse; load data or store acknowledge
- `d_rdata`  out  32  load data; 0 for a store acknowledge
- `mem_addr`  out  32  to `Memory.addr`
- `mem_read_en`  out  1  to `Memory.read_en`
- `mem_write_en`  out  1  to `Memory.write_en`
- `mem_wr_data`  out  32  to `Memory.wr_data`
- `mem_write_type`  out  2  to `Memory.write_type`
- `mem_rd_type`  out  3  to `Memory.rd_type`
- `mem_out`  in  32  from `Memory.out` (combinational read data)

## Operation
- **FSM states:** IDLE, RESP.
  - IDLE with no request: all `mem_*` outputs and grants are 0.
  - IDLE with `if_req` or `d_req` high: choose a winner, pulse its `*_gnt`, drive the `mem_*` outputs combinationally this cycle, latch the owner, go to RESP.
- **Arbitration:**
  - Only `d_req`: data wins.
  - Only `if_req`: fetch wins.
  - Both: data wins unless `streak == MAX_DATA_STREAK`, in which case fetch wins.
- **Streak counter** (4 bits):
  - Increments on a data grant issued while `if_req` = 1.
  - Clears on any fetch grant, or on a data grant while `if_req` = 0.
  - Saturates at `MAX_DATA_STREAK`.
- **Fetch grant outputs:** `mem_addr` = `if_addr`, `mem_read_en` = 1, `mem_write_en` = 0, `mem_rd_type` = `FETCH_RD_TYPE`, `mem_write_type` = 0, `mem_wr_data` = 0.
- **Data grant outputs:** `mem_addr` = `d_addr`, `mem_read_en` = 1 (required by the write-data unit for partial-store merge), `mem_write_en` = `d_we`, `mem_wr_data` = `d_wdata`, `mem_write_type` = `d_wtype`, `mem_rd_type` = `d_rtype`.
- **Grant-cycle capture:** at the clock edge ending the grant cycle, capture `mem_out` into the owner's rdata register; a store captures 0. The store commits to RAM/I/O on this same edge.
- **RESP:** pulse the owner's `*_rvalid` and hold its `*_rdata` stable. All `mem_*` outputs are 0 and no grants are issued. Return to IDLE.
- `*_rdata` holds its last value until the next capture for that owner.
- Requests arriving in RESP wait; they are evaluated in the following IDLE cycle.
- A requester deasserting its request before grant is legal; it is simply not served.

## Timing
- **Reset** (`rst` = 0 at an edge): state = IDLE, streak = 0. All outputs are 0 in the following cycle, including `*_rdata`, `mem_addr`, grants and rvalids.
- **Reset mid-operation:**
  - During RESP: the pending rvalid is suppressed.
  - During a grant cycle: `mem_write_en` is still combinationally asserted, so the store commits on that edge. The response is dropped.
- **Latency:** grant in cycle N (same cycle the request is first seen in IDLE); rvalid and rdata in cycle N+1.
- **Throughput:** one access per 2 cycles; back-to-back grants are at least 2 cycles apart.
- **Exclusivity:** at most one of `if_gnt`/`d_gnt` is high per cycle; at most one rvalid is high per cycle. A grant and an rvalid are never high in the same cycle.
- **Starvation bound:** with both requesting continuously, fetch is granted at least once every `MAX_DATA_STREAK`+1 grants.

## Test plan
- **Reset:** hold `rst` = 0 two cycles with both requests high -> all outputs 0, no grants.
- **Lone fetch:** `if_req`, `if_addr` = 0x100, `mem_out` = 0xDEADBEEF -> `if_gnt` in cycle 0 with `mem_addr` = 0x100, `mem_rd_type` = 3'b010; `if_rvalid` with `if_rdata` = 0xDEADBEEF in cycle 1.
- **Store:** `d_req`, `d_we` = 1, `d_addr` = 0x2000, `d_wdata` = 0x55, `d_wtype` = 2'b00 -> `d_gnt` with `mem_write_en` = 1 and `mem_read_en` = 1 in cycle 0; `d_rvalid` with `d_rdata` = 0 in cycle 1.
- **Contention, default `MAX_DATA_STREAK` = 4:** both requests held continuously -> grant order D,D,D,D,I,D,D,D,D,I; grants on even cycles only.
- **Simultaneous start, streak = 0:** both requests rise in the same cycle -> `d_gnt` first; `if_gnt` 2 cycles later once `d_req` drops.
- **Reset mid-operation:** assert `rst` = 0 in the RESP cycle of a load -> no `d_rvalid`, `d_rdata` = 0, state IDLE.
